wb_select_unit: RTL and testbench
=================================

WB_SELECT_UNIT -- requirements
Module: wb_select_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning datapath width; legal values 32 or 64.
REQ-002 The block SHALL have parameter REG_AW, default 5, meaning register-index width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, meaning maximum load-wait cycles when the timeout feature is compiled in.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 in_valid  input  1  instruction presented.
REQ-007 in_ready  output  1  block can accept an instruction.
REQ-008 mem_en, mem_wen  input  1 each  memory access and write flags.
REQ-009 alu_result  input  DATA_W  ALU result, which is also the load address.
REQ-010 rd  input  REG_AW  destination register.
REQ-011 reg_wen  input  1  instruction writes rd.
REQ-012 ld_size  input  2  0=byte, 1=half, 2=word, 3=dword (dword legal only when DATA_W=64).
REQ-013 ld_unsigned  input  1  zero-extend rather than sign-extend.
REQ-014 mem_rdata  input  DATA_W  load data; mem_rvalid  input  1  load data valid.
REQ-015 wb_valid  output  1  one-cycle completion pulse; wb_wen  output  1; wb_rd  output  REG_AW; wb_data  output  DATA_W.
REQ-016 ld_err  output  1  sticky load-timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_MEM and DONE; in_ready SHALL equal (state==IDLE).
REQ-018 An accepted instruction is one with in_valid=1 and in_ready=1; rd, reg_wen, ld_size, ld_unsigned, alu_result and the two memory flags SHALL be captured on acceptance.
REQ-019 A load is mem_en=1 with mem_wen=0; acceptance of a load SHALL move the FSM IDLE->WAIT_MEM.
REQ-020 A non-load SHALL move the FSM IDLE->DONE, with wb_data=alu_result and wb_wen=reg_wen; a store (mem_en=1, mem_wen=1) SHALL force wb_wen=0.
REQ-021 In WAIT_MEM, mem_rvalid=1 SHALL capture the extracted load data and move the FSM to DONE; mem_rvalid outside WAIT_MEM SHALL be ignored.
REQ-022 Load extraction SHALL be little-endian: the lane offset is alu_result[log2(DATA_W/8)-1:0] aligned down to the access size, and the result is sign- or zero-extended to DATA_W per ld_unsigned; ld_size=2 with DATA_W=32 and ld_size=3 SHALL pass data unchanged.
REQ-023 In DONE, wb_valid SHALL be 1 for exactly one cycle and the FSM SHALL then return to IDLE; wb_rd, wb_data and wb_wen SHALL hold their values until the next DONE.
REQ-024 Latency from acceptance to wb_valid SHALL be 1 cycle for a non-load and (N+1) cycles for a load whose mem_rvalid arrives N cycles after acceptance (N>=1).
REQ-025 Throughput SHALL be one instruction per 2 cycles maximum; in_valid while in_ready=0 SHALL NOT be captured.
REQ-026 wb_wen SHALL be 0 whenever wb_valid is 0.

Reset
REQ-027 With rst=1 at a rising edge, the state SHALL become IDLE and wb_valid, wb_wen, wb_rd, wb_data and ld_err SHALL become 0; rst SHALL have priority over every other event.
REQ-028 Reset in WAIT_MEM SHALL abandon the load, and a mem_rvalid arriving after reset SHALL be ignored.

Configuration
REQ-029 Macro WB_LOAD_TIMEOUT_EN SHALL gate the timeout feature.
REQ-030 With WB_LOAD_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT_MEM and increment each cycle in WAIT_MEM without mem_rvalid; when it reaches TIMEOUT, the FSM SHALL go to DONE with wb_wen=0 and wb_data=0, and ld_err SHALL be set and held until reset; mem_rvalid in that same cycle SHALL win.
REQ-031 Without WB_LOAD_TIMEOUT_EN, WAIT_MEM SHALL wait indefinitely, ld_err SHALL be tied to 0, and no counter SHALL exist.

Verification
REQ-032 ALU op: alu_result=0x0000_1234, rd=3, reg_wen=1 -> next cycle wb_valid=1, wb_rd=3, wb_data=0x0000_1234, wb_wen=1.
REQ-033 Signed byte load: addr low bits=2'b01, mem_rdata=0x1122_80FF, ld_size=0, mem_rvalid 3 cycles after acceptance -> wb_data=0xFFFF_FF80, wb_valid 4 cycles after acceptance.
REQ-034 Unsigned half load: addr[1:0]=2'b10, mem_rdata=0x8001_0000, ld_unsigned=1 -> wb_data=0x0000_8001.
REQ-035 Store: mem_en=1, mem_wen=1, reg_wen=1 -> wb_valid=1, wb_wen=0 one cycle later; a spurious mem_rvalid in IDLE causes no output.
REQ-036 Assert rst in WAIT_MEM, then drive mem_rvalid -> no wb_valid, all outputs 0, in_ready=1.
REQ-037 With WB_LOAD_TIMEOUT_EN defined and TIMEOUT=15, a load with mem_rvalid never asserted -> wb_valid with wb_wen=0 15 cycles after WAIT_MEM entry, and ld_err stays 1 until rst.

Source files
------------

// File: rtl/wb_select_unit_if.sv
// Instruction, load-data and writeback signals of wb_select_unit.
// master = instruction/memory source, slave = wb_select_unit.
interface wb_select_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              mem_en;
  logic              mem_wen;
  logic [DATA_W-1:0] alu_result;
  logic [REG_AW-1:0] rd;
  logic              reg_wen;
  logic [1:0]        ld_size;
  logic              ld_unsigned;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              wb_valid;
  logic              wb_wen;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output in_valid, mem_en, mem_wen, alu_result, rd, reg_wen, ld_size,
           ld_unsigned, mem_rdata, mem_rvalid,
    input  in_ready, wb_valid, wb_wen, wb_rd, wb_data
  );

  modport slave (
    input  in_valid, mem_en, mem_wen, alu_result, rd, reg_wen, ld_size,
           ld_unsigned, mem_rdata, mem_rvalid,
    output in_ready, wb_valid, wb_wen, wb_rd, wb_data
  );
endinterface

// File: rtl/wb_select_unit.sv
// Writeback select: ALU results pass straight through, loads are lane-extracted and extended.
// Optional load timeout (ld_err) is compiled in with WB_LOAD_TIMEOUT_EN.
module wb_select_unit #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  wb_select_unit_if.slave bus,
  output logic            ld_err
);
  // state    | meaning
  // IDLE     | ready to accept an instruction
  // WAIT_MEM | load accepted, waiting for mem_rvalid
  // DONE     | one-cycle writeback pulse on wb_valid
  typedef enum logic [1:0] {IDLE, WAIT_MEM, DONE} state_t;

  localparam int OFF_W = $clog2(DATA_W / 8);

  if ((DATA_W != 32 && DATA_W != 64) || TIMEOUT < 1) begin : g_param_check
    $error("wb_select_unit: unsupported DATA_W or TIMEOUT");
  end

  state_t            state_q, state_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              reg_wen_q, reg_wen_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              ld_unsigned_q, ld_unsigned_d;
  logic [OFF_W-1:0]  lane_q, lane_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_wen_q, wb_wen_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [OFF_W-1:0]  lane_mask, lane;
  logic [DATA_W-1:0] shifted, load_data;
`ifdef WB_LOAD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ld_err_q, ld_err_d;
`endif

  // Lane offset aligned down to the access size, then little-endian extract.
  always_comb begin
    lane_mask = '1;
    for (int i = 0; i < OFF_W; i++) begin
      if (i < int'(ld_size_q)) lane_mask[i] = 1'b0;
    end
    lane    = lane_q & lane_mask;
    shifted = bus.mem_rdata >> {lane, 3'b000};
    case (ld_size_q)
      2'd0: begin
        if (ld_unsigned_q) load_data = DATA_W'(shifted[7:0]);
        else               load_data = DATA_W'($signed(shifted[7:0]));
      end
      2'd1: begin
        if (ld_unsigned_q) load_data = DATA_W'(shifted[15:0]);
        else               load_data = DATA_W'($signed(shifted[15:0]));
      end
      2'd2: begin
        if (ld_unsigned_q) load_data = DATA_W'(shifted[31:0]);
        else               load_data = DATA_W'($signed(shifted[31:0]));
      end
      default: load_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    rd_d          = rd_q;
    reg_wen_d     = reg_wen_q;
    ld_size_d     = ld_size_q;
    ld_unsigned_d = ld_unsigned_q;
    lane_d        = lane_q;
    wb_valid_d    = 1'b0;
    wb_wen_d      = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
`ifdef WB_LOAD_TIMEOUT_EN
    cnt_d         = cnt_q;
    ld_err_d      = ld_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          rd_d          = bus.rd;
          reg_wen_d     = bus.reg_wen;
          ld_size_d     = bus.ld_size;
          ld_unsigned_d = bus.ld_unsigned;
          lane_d        = bus.alu_result[OFF_W-1:0];
          if (bus.mem_en && !bus.mem_wen) begin
            state_d = WAIT_MEM;
`ifdef WB_LOAD_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            // Non-load with mem_en set is a store: never writes the register file.
            state_d    = DONE;
            wb_valid_d = 1'b1;
            wb_wen_d   = bus.reg_wen && !bus.mem_en;
            wb_rd_d    = bus.rd;
            wb_data_d  = bus.alu_result;
          end
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          state_d    = DONE;
          wb_valid_d = 1'b1;
          wb_wen_d   = reg_wen_q;
          wb_rd_d    = rd_q;
          wb_data_d  = load_data;
        end
`ifdef WB_LOAD_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d    = DONE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = '0;
          ld_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rd_q          <= '0;
      reg_wen_q     <= 1'b0;
      ld_size_q     <= 2'd0;
      ld_unsigned_q <= 1'b0;
      lane_q        <= '0;
      wb_valid_q    <= 1'b0;
      wb_wen_q      <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
`ifdef WB_LOAD_TIMEOUT_EN
      cnt_q         <= '0;
      ld_err_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rd_q          <= rd_d;
      reg_wen_q     <= reg_wen_d;
      ld_size_q     <= ld_size_d;
      ld_unsigned_q <= ld_unsigned_d;
      lane_q        <= lane_d;
      wb_valid_q    <= wb_valid_d;
      wb_wen_q      <= wb_wen_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
`ifdef WB_LOAD_TIMEOUT_EN
      cnt_q         <= cnt_d;
      ld_err_q      <= ld_err_d;
`endif
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_wen   = wb_wen_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
`ifdef WB_LOAD_TIMEOUT_EN
  assign ld_err = ld_err_q;
`else
  assign ld_err = 1'b0;
`endif
endmodule

// File: tb/tb_wb_select_unit.sv
// Bench for wb_select_unit: expected writebacks are scheduled by cycle number from the
// instruction/latency rules and compared against the DUT on every cycle.
module tb_wb_select_unit;
  localparam int BIG = 1 << 30;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wen;
    bit          tmo;
  } wb_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld_err;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  bit   checking = 1'b0;

  wb_exp_t     q[$];
  wb_exp_t     cur;
  int          busy_from = BIG;
  int          busy_to = -1;
  logic [4:0]  held_rd = '0;
  logic [31:0] held_data = '0;
  logic        exp_err = 1'b0;
  logic [4:0]  pl_rd;
  logic [31:0] pl_alu;
  logic [1:0]  pl_sz;
  logic        pl_uns, pl_rwen;

  wb_select_unit_if #(.DATA_W(32), .REG_AW(5)) bus ();

  wb_select_unit #(.DATA_W(32), .REG_AW(5), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .ld_err(ld_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit exp_ready(input int k);
    return !(k >= busy_from && k <= busy_to);
  endfunction

  function automatic logic [31:0] m_extract(input logic [31:0] d, input logic [31:0] addr,
                                            input logic [1:0] sz, input logic uns);
    int nb, off;
    logic [31:0] v;
    if (sz >= 2'd2) return d;
    nb  = (sz == 2'd0) ? 1 : 2;
    off = int'(addr[1:0]);
    off = off - (off % nb);
    v   = d >> (8 * off);
    if (nb == 1) begin
      v = v & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      bit exp_v;
      exp_v = (q.size() > 0) && (q[0].cyc == cyc);
      if (exp_v) begin
        cur       = q.pop_front();
        held_rd   = cur.rd;
        held_data = cur.data;
        if (cur.tmo) exp_err = 1'b1;
      end
      chk("wb_valid", 32'(bus.wb_valid), 32'(exp_v));
      chk("wb_wen", 32'(bus.wb_wen), exp_v ? 32'(cur.wen) : 32'd0);
      chk("wb_rd", 32'(bus.wb_rd), 32'(held_rd));
      chk("wb_data", bus.wb_data, held_data);
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ready(cyc)));
      chk("ld_err", 32'(ld_err), 32'(exp_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    busy_from = BIG;
    busy_to   = -1;
    held_rd   = '0;
    held_data = '0;
    exp_err   = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    step();
    model_reset();
    repeat (n - 1) step();
    rst = 1'b0;
  endtask

  // Present one instruction for one cycle; the model decides whether it is accepted.
  task automatic present(input logic men, input logic mwen, input logic rwen, input logic [4:0] rdv,
                         input logic [31:0] alu, input logic [1:0] sz, input logic uns);
    bit ok;
    bus.in_valid    = 1'b1;
    bus.mem_en      = men;
    bus.mem_wen     = mwen;
    bus.reg_wen     = rwen;
    bus.rd          = rdv;
    bus.alu_result  = alu;
    bus.ld_size     = sz;
    bus.ld_unsigned = uns;
    ok = exp_ready(cyc);
    step();
    if (ok) begin
      busy_from = cyc;
      if (men && !mwen) begin
        busy_to = BIG;
        pl_rd = rdv; pl_alu = alu; pl_sz = sz; pl_uns = uns; pl_rwen = rwen;
      end else begin
        busy_to = cyc;
        q.push_back('{cyc: cyc, rd: rdv, data: alu, wen: rwen && !men, tmo: 1'b0});
      end
    end
  endtask

  task automatic deliver(input int n, input logic [31:0] rdata, input bit use_lit,
                         input logic [31:0] lit);
    logic [31:0] d;
    repeat (n - 1) step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    d = use_lit ? lit : m_extract(rdata, pl_alu, pl_sz, pl_uns);
    q.push_back('{cyc: cyc + 1, rd: pl_rd, data: d, wen: pl_rwen, tmo: 1'b0});
    busy_to = cyc + 1;
    step();
    bus.mem_rvalid = 1'b0;
    step();
  endtask

  task automatic do_op(input logic men, input logic mwen, input logic rwen,
                       input logic [4:0] rdv, input logic [31:0] alu);
    present(men, mwen, rwen, rdv, alu, 2'd0, 1'b0);
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic do_load(input logic [4:0] rdv, input logic [31:0] alu, input logic [1:0] sz,
                         input logic uns, input logic rwen, input int n, input logic [31:0] rdata,
                         input bit use_lit, input logic [31:0] lit);
    present(1'b1, 1'b0, rwen, rdv, alu, sz, uns);
    bus.in_valid = 1'b0;
    deliver(n, rdata, use_lit, lit);
  endtask

  initial begin
    bus.in_valid = 0; bus.mem_en = 0; bus.mem_wen = 0; bus.alu_result = '0; bus.rd = '0;
    bus.reg_wen = 0; bus.ld_size = '0; bus.ld_unsigned = 0; bus.mem_rdata = '0; bus.mem_rvalid = 0;
    do_reset(2);
    checking = 1'b1;
    step();

    do_op(1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_1234);
    do_load(5'd5, 32'h0000_2001, 2'd0, 1'b0, 1'b1, 3, 32'h1122_80FF, 1'b1, 32'hFFFF_FF80);
    do_load(5'd7, 32'h0000_3002, 2'd1, 1'b1, 1'b1, 1, 32'h8001_0000, 1'b1, 32'h0000_8001);
    do_load(5'd8, 32'h0000_3003, 2'd1, 1'b0, 1'b1, 2, 32'hF00D_1234, 1'b1, 32'hFFFF_F00D);
    do_load(5'd10, 32'h0000_0003, 2'd2, 1'b0, 1'b1, 1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);

    do_op(1'b1, 1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    step(); step();
    bus.mem_rvalid = 1'b0;
    step();

    do_load(5'd11, 32'h0000_0002, 2'd1, 1'b0, 1'b1, 2, 32'h8001_0000, 1'b0, '0);
    do_load(5'd12, 32'h0000_0003, 2'd0, 1'b1, 1'b1, 1, 32'hA500_0000, 1'b0, '0);
    do_load(5'd13, 32'h0000_0000, 2'd0, 1'b0, 1'b1, 4, 32'h1234_567F, 1'b0, '0);
    do_load(5'd14, 32'h0000_0001, 2'd3, 1'b0, 1'b1, 1, 32'h8765_4321, 1'b0, '0);
    do_load(5'd15, 32'h0000_0001, 2'd0, 1'b0, 1'b0, 2, 32'h0000_FF00, 1'b0, '0);
    do_op(1'b0, 1'b1, 1'b1, 5'd16, 32'h0BAD_F00D);
    do_op(1'b0, 1'b0, 1'b0, 5'd17, 32'h7777_0001);

    for (int i = 0; i < 4; i++) present(1'b0, 1'b0, 1'b1, 5'(20 + i), 32'h100 + 32'(i), 2'd0, 1'b0);
    bus.in_valid = 1'b0;
    step(); step();

    present(1'b1, 1'b0, 1'b1, 5'd25, 32'h0000_0001, 2'd0, 1'b1);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) present(1'b0, 1'b0, 1'b1, 5'd26, 32'h9999_0000, 2'd0, 1'b0);
    bus.in_valid = 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
    deliver(5, 32'h0000_C300, 1'b0, '0);
`else
    deliver(37, 32'h0000_C300, 1'b0, '0);
`endif

    present(1'b1, 1'b0, 1'b1, 5'd27, 32'h0000_0000, 2'd2, 1'b0);
    bus.in_valid = 1'b0;
    step(); step();
    do_reset(2);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    step(); step();
    bus.mem_rvalid = 1'b0;
    step();

`ifdef WB_LOAD_TIMEOUT_EN
    present(1'b1, 1'b0, 1'b1, 5'd28, 32'h0000_0000, 2'd2, 1'b0);
    bus.in_valid = 1'b0;
    q.push_back('{cyc: cyc + 15, rd: 5'd28, data: 32'h0, wen: 1'b0, tmo: 1'b1});
    busy_to = cyc + 15;
    repeat (20) step();
    do_load(5'd29, 32'h0000_0000, 2'd2, 1'b0, 1'b1, 15, 32'h0123_4567, 1'b0, '0);
    do_reset(1);
    step();
`endif

    repeat (3) step();
    chk("pending_wb", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end
endmodule
